// File: rtl/regfile_nport.sv
// regfile_nport
//   Multi-port register file: 2^ADDR_W words of DATA_W bits, one write port and
//   NUM_RD independent read ports with write-first bypass. Optional registered
//   read (REG_RD=1) and optional hardwired-zero word 0 (ZERO_REG=1).
//
// Ports
//   Clk     in   clock, all state updates on rising edge
//   Rst     in   asynchronous active-high reset (clears storage and read registers)
//   Clr     in   synchronous clear of every word, wins over a concurrent write
//   WrEn    in   write enable
//   WrAddr  in   write address
//   WrData  in   write data
//   RdEn    in   per-port read enable (only meaningful when REG_RD=1)
//   RdAddr  in   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   RdData  out  packed read data, port k at [k*DATA_W +: DATA_W]
module regfile_nport #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned REG_RD   = 0
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Clr,
    input  logic                     WrEn,
    input  logic [ADDR_W-1:0]        WrAddr,
    input  logic [DATA_W-1:0]        WrData,
    input  logic [NUM_RD-1:0]        RdEn,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_ok;

    // Writes to word 0 are dropped when it is hardwired to zero.
    assign w_wr_ok = WrEn && !((ZERO_REG != 0) && (WrAddr == '0));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (Clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[WrAddr] <= WrData;
        end
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_port
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_val;

        assign w_addr = RdAddr[k*ADDR_W +: ADDR_W];

        // Read value with write-first bypass. A pending clear (or reset, during
        // which writes are ignored) hides the bypass and the stored data.
        always_comb begin
            w_val = r_mem[w_addr];
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_val = '0;
            end else if (Clr || Rst) begin
                w_val = '0;
            end else if (WrEn && (WrAddr == w_addr)) begin
                w_val = WrData;
            end
        end

        if (REG_RD != 0) begin : g_reg
            logic [DATA_W-1:0] r_rd;

            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    r_rd <= '0;
                end else if (RdEn[k]) begin
                    r_rd <= w_val;
                end
            end

            assign RdData[k*DATA_W +: DATA_W] = r_rd;
        end else begin : g_comb
            logic w_unused_rden;

            assign w_unused_rden = RdEn[k];
            assign RdData[k*DATA_W +: DATA_W] = w_val;
        end
    end

endmodule

// File: doc/regfile_nport.md
# regfile_nport

Parametrised multi-port register file replacing the fixed 32×32 read multiplexer in the datapath decode stage. Holds 2^ADDR_W words of DATA_W bits, accepts one write per clock and serves NUM_RD independent read ports, each with write-first bypass. An optional registered-read mode eases timing into the execute stage. Register 0 can be hardwired to zero for the MIPS ISA.

## Interface
- DATA_W, 32, word width in bits.
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W words.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = word 0 always reads 0 and ignores writes.
- REG_RD, 0, 0 = combinational read; 1 = read data registered on Clk.

- Clk  in  1  clock; all state updates on its rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Clr  in  1  synchronous clear of all words (priority over write).
- WrEn  in  1  write enable.
- WrAddr  in  ADDR_W  write address.
- WrData  in  DATA_W  write data.
- RdEn  in  NUM_RD  per-port read enable (used only when REG_RD=1).
- RdAddr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- RdData  out  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W].

## Operation
- Storage: DEPTH words, all 0 after Rst.
- Write: on a rising edge with WrEn=1 and Clr=0, mem[WrAddr] <= WrData. If ZERO_REG=1 and WrAddr=0, the write is dropped.
- Clr=1 at a rising edge: every word <= 0; any concurrent write is discarded.
- Read value for port k, val_k:
  - ZERO_REG=1 and RdAddr_k=0 -> 0.
  - Else Clr=1 -> 0.
  - Else WrEn=1 and WrAddr=RdAddr_k -> WrData (bypass).
  - Else mem[RdAddr_k].
- REG_RD=0: RdData_k = val_k combinationally. Undefined enables are ignored.
- REG_RD=1: on a rising edge with RdEn[k]=1, RdData_k <= val_k. With RdEn[k]=0 it holds.
- Ports are fully independent. Any ports may read the same address, including the write address, in the same cycle.
- Out-of-range addresses cannot occur because DEPTH = 2^ADDR_W. All arithmetic is unsigned and index only.

## Timing
- Rst asserted at any time, including mid-write: all words and all RdData registers clear to 0 immediately. While Rst is high, writes and Clr have no effect.
- Reset values:
  - REG_RD=1: RdData = 0.
  - REG_RD=0: RdData = val_k = 0 for all addresses.
- Write latency: 1 edge. A read in the cycle after the write returns the new data with no bypass required.
- Read latency:
  - REG_RD=0: 0 cycles. The bypass makes a same-cycle write visible combinationally.
  - REG_RD=1: 1 cycle. The value captured reflects the write occurring at that same edge, i.e. write-first.
- Clr and WrEn both asserted: the clear wins. The next-cycle read of WrAddr returns 0.
- Back-to-back writes to the same address: the last one wins. The bypass always reflects the current-cycle WrData.
- No back-pressure and no stall. The block accepts one write and NUM_RD reads every cycle.

## Test plan
- Reset: Rst pulse with REG_RD=1, NUM_RD=2 -> RdData=0. Read all 32 addresses -> every value 0.
- Write/read: write 0xDEADBEEF to address 5. Next cycle, port 0 reads 5 and port 1 reads 6 -> 0xDEADBEEF and 0x00000000.
- Bypass:
  - WrEn=1, WrAddr=7, WrData=0x12345678, both ports reading 7 in the same cycle.
  - REG_RD=0 -> both ports show 0x12345678 in that cycle.
  - REG_RD=1 -> both ports show 0x12345678 after the edge.
- Zero register: write 0xFFFFFFFF to address 0, read 0 both same-cycle and next cycle -> 0 both times. Repeat with ZERO_REG=0 -> 0xFFFFFFFF next cycle.
- Clear vs write: fill addresses 1..31 with their own index. Assert Clr with WrEn=1, WrAddr=3, WrData=0xAA -> all reads return 0 afterwards, including address 3.
- Async reset mid-operation and RdEn hold:
  - With REG_RD=1, port 0 is holding 0x55 with RdEn[0]=0 while address 2 changes -> output stays 0x55.
  - Assert Rst between edges -> RdData drops to 0 before the next edge.
  - Address 2 later reads 0.
